// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the 5-stage MIPS core: datapath widths, ALU op
// encodings, writeback/destination select encodings and the packed control
// bundle that travels down the pipeline.
// No ports (package).

package core_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int ALU_OP_W   = 4;
   localparam int SHAMT_W    = 5;

   // ALU operation codes as produced by the ALU control decode
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_AND = 4'd0,
      ALU_OR  = 4'd1,
      ALU_ADD = 4'd2,
      ALU_XOR = 4'd3,
      ALU_SLL = 4'd4,
      ALU_SRL = 4'd5,
      ALU_SUB = 4'd6,
      ALU_SLT = 4'd7,
      ALU_SRA = 4'd8,
      ALU_LUI = 4'd9,
      ALU_NOR = 4'd12
   } aluOp_e;

   // Writeback source select
   typedef enum logic [1:0] {
      MEM_TO_REG_ALU = 2'b00,
      MEM_TO_REG_MEM = 2'b01,
      MEM_TO_REG_PC4 = 2'b10
   } memToReg_e;

   // Destination register select ($31 for jal-style links)
   typedef enum logic [1:0] {
      REG_DST_RT = 2'b00,
      REG_DST_RD = 2'b01,
      REG_DST_RA = 2'b10
   } regDst_e;

   // Control bundle. Fields are plain vectors so that any encoding the
   // decoder emits is carried through unchanged.
   typedef struct packed {
      logic                regWrite;
      logic                memRead;
      logic                memWrite;
      logic                aluSrc;
      logic                branch;
      logic [1:0]          memToReg;
      logic [1:0]          regDst;
      logic [ALU_OP_W-1:0] aluOp;
   } ctrl_t;

   // A bubble is an all-zero control word: no writes, no memory access
   localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if
// Bundles the ID-side inputs and EX-side outputs of the ID/EX pipeline
// register. The master modport is the producer/consumer side (ID drives
// id_*, EX observes ex_*); the slave modport is the pipeline register.
// Parameter: CNT_W - width of the debug bubble counter.

interface id_ex_reg_if #(parameter int CNT_W = 16);
   import core_pkg::*;

   logic                  id_valid;
   logic [DATA_W-1:0]     id_pc_plus4;
   logic [DATA_W-1:0]     id_rs_data;
   logic [DATA_W-1:0]     id_rt_data;
   logic [DATA_W-1:0]     id_imm_ext;
   logic [DATA_W-1:0]     id_imm_shift;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic [SHAMT_W-1:0]    id_shamt;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  id_mem_write;
   logic                  id_alu_src;
   logic                  id_branch;
   logic [1:0]            id_mem_to_reg;
   logic [1:0]            id_reg_dst;
   logic [ALU_OP_W-1:0]   id_alu_op;

   logic                  ex_valid;
   logic [DATA_W-1:0]     ex_pc_plus4;
   logic [DATA_W-1:0]     ex_rs_data;
   logic [DATA_W-1:0]     ex_rt_data;
   logic [DATA_W-1:0]     ex_imm_ext;
   logic [DATA_W-1:0]     ex_imm_shift;
   logic [REG_ADDR_W-1:0] ex_rs;
   logic [REG_ADDR_W-1:0] ex_rt;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [SHAMT_W-1:0]    ex_shamt;
   logic                  ex_reg_write;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic                  ex_alu_src;
   logic                  ex_branch;
   logic [1:0]            ex_mem_to_reg;
   logic [1:0]            ex_reg_dst;
   logic [ALU_OP_W-1:0]   ex_alu_op;
   logic [DATA_W-1:0]     ex_branch_target;
   logic [CNT_W-1:0]      bubble_count;

   modport master (
      output id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
             id_imm_shift, id_rs, id_rt, id_rd, id_shamt, id_reg_write,
             id_mem_read, id_mem_write, id_alu_src, id_branch,
             id_mem_to_reg, id_reg_dst, id_alu_op,
      input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
             ex_imm_shift, ex_rs, ex_rt, ex_rd, ex_shamt, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_alu_src, ex_branch,
             ex_mem_to_reg, ex_reg_dst, ex_alu_op, ex_branch_target,
             bubble_count
   );

   modport slave (
      input  id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
             id_imm_shift, id_rs, id_rt, id_rd, id_shamt, id_reg_write,
             id_mem_read, id_mem_write, id_alu_src, id_branch,
             id_mem_to_reg, id_reg_dst, id_alu_op,
      output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
             ex_imm_shift, ex_rs, ex_rt, ex_rd, ex_shamt, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_alu_src, ex_branch,
             ex_mem_to_reg, ex_reg_dst, ex_alu_op, ex_branch_target,
             bubble_count
   );

endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous active-high reset. Once the count
// reaches all ones further increments are dropped, so it never wraps.
// Ports:
//   clk   - clock
//   reset - synchronous clear (wins over inc)
//   inc   - add one this cycle if not saturated
//   count - current value

module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Clear on reset, otherwise step by one until all ones is reached
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg
// ID/EX pipeline register of the 5-stage MIPS core. Captures operands,
// immediates, specifiers and the control bundle, and precomputes the branch
// target (PC+4 + shifted immediate, carry dropped) so EX does not need an
// adder on that path. The hazard unit can hold the stage (stall) or replace
// its content with a bubble (flush); flush wins over stall. Flush-inserted
// bubbles are counted for debug.
// Ports:
//   clk   - core clock
//   reset - synchronous active-high reset, clears everything
//   stall - hold stage contents
//   flush - load a bubble, bump bubble counter
//   bus   - id_ex_reg_if slave: id_* in, ex_* / bubble_count out
// Data widths come from core_pkg; CNT_W sizes the bubble counter.

module id_ex_reg
   import core_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   id_ex_reg_if.slave    bus
);

   logic                  exValid;
   logic [DATA_W-1:0]     exPcPlus4;
   logic [DATA_W-1:0]     exRsData;
   logic [DATA_W-1:0]     exRtData;
   logic [DATA_W-1:0]     exImmExt;
   logic [DATA_W-1:0]     exImmShift;
   logic [DATA_W-1:0]     exBranchTarget;
   logic [REG_ADDR_W-1:0] exRs;
   logic [REG_ADDR_W-1:0] exRt;
   logic [REG_ADDR_W-1:0] exRd;
   logic [SHAMT_W-1:0]    exShamt;
   ctrl_t                 exCtrl;

   ctrl_t                 idCtrl;
   logic [DATA_W-1:0]     branchTargetNext;
   logic [CNT_W-1:0]      bubbleCount;

   // Gather the loose ID control bits into one bundle so bubble insertion
   // is a single assignment of BUBBLE
   assign idCtrl = '{
      regWrite: bus.id_reg_write,
      memRead:  bus.id_mem_read,
      memWrite: bus.id_mem_write,
      aluSrc:   bus.id_alu_src,
      branch:   bus.id_branch,
      memToReg: bus.id_mem_to_reg,
      regDst:   bus.id_reg_dst,
      aluOp:    bus.id_alu_op
   };

   // Branch target computed in ID; the sum is truncated to DATA_W so a
   // target past the top of the address space wraps
   assign branchTargetNext = bus.id_pc_plus4 + bus.id_imm_shift;

   // Stage register. Reset and flush both produce an all-zero stage; the
   // difference is only that flush is counted. Stall simply skips the load.
   // id_valid=0 still captures the fields, it just marks EX as empty.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         exValid        <= 1'b0;
         exPcPlus4      <= '0;
         exRsData       <= '0;
         exRtData       <= '0;
         exImmExt       <= '0;
         exImmShift     <= '0;
         exBranchTarget <= '0;
         exRs           <= '0;
         exRt           <= '0;
         exRd           <= '0;
         exShamt        <= '0;
         exCtrl         <= BUBBLE;
      end else if (!stall) begin
         exValid        <= bus.id_valid;
         exPcPlus4      <= bus.id_pc_plus4;
         exRsData       <= bus.id_rs_data;
         exRtData       <= bus.id_rt_data;
         exImmExt       <= bus.id_imm_ext;
         exImmShift     <= bus.id_imm_shift;
         exBranchTarget <= branchTargetNext;
         exRs           <= bus.id_rs;
         exRt           <= bus.id_rt;
         exRd           <= bus.id_rd;
         exShamt        <= bus.id_shamt;
         exCtrl         <= idCtrl;
      end
   end

   // Bubble counter; reset has priority inside the counter, and a stall
   // without flush leaves it untouched because inc is low
   sat_counter #(
      .WIDTH (CNT_W)
   ) bubbleCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (flush),
      .count (bubbleCount)
   );

   assign bus.ex_valid         = exValid;
   assign bus.ex_pc_plus4      = exPcPlus4;
   assign bus.ex_rs_data       = exRsData;
   assign bus.ex_rt_data       = exRtData;
   assign bus.ex_imm_ext       = exImmExt;
   assign bus.ex_imm_shift     = exImmShift;
   assign bus.ex_branch_target = exBranchTarget;
   assign bus.ex_rs            = exRs;
   assign bus.ex_rt            = exRt;
   assign bus.ex_rd            = exRd;
   assign bus.ex_shamt         = exShamt;
   assign bus.ex_reg_write     = exCtrl.regWrite;
   assign bus.ex_mem_read      = exCtrl.memRead;
   assign bus.ex_mem_write     = exCtrl.memWrite;
   assign bus.ex_alu_src       = exCtrl.aluSrc;
   assign bus.ex_branch        = exCtrl.branch;
   assign bus.ex_mem_to_reg    = exCtrl.memToReg;
   assign bus.ex_reg_dst       = exCtrl.regDst;
   assign bus.ex_alu_op        = exCtrl.aluOp;
   assign bus.bubble_count     = bubbleCount;

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the ID stage (register file, control decode, immediate extension) and the EX stage of the 5-stage MIPS core.
- Captures decoded operands, the extended immediate, its shifted branch offset and control signals.
- Precomputes the branch target at capture time.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Counts inserted bubbles for debug.

Parameters:
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register specifier width
- ALU_OP_W, 4, ALU operation code width
- CNT_W, 16, width of bubble counter

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all stage contents this cycle
- flush  input  1  replace captured content with a bubble
- id_valid  input  1  ID stage holds a real instruction
- id_pc_plus4  input  DATA_W  PC+4 of ID instruction
- id_rs_data  input  DATA_W  register file read port 1
- id_rt_data  input  DATA_W  register file read port 2
- id_imm_ext  input  DATA_W  extended or lui-formed immediate
- id_imm_shift  input  DATA_W  extended immediate shifted left 2
- id_rs, id_rt, id_rd  input  REG_ADDR_W each  register specifiers
- id_shamt  input  5  shift amount field
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch  input  1 each  control bits
- id_mem_to_reg, id_reg_dst  input  2 each  writeback/destination selects
- id_alu_op  input  ALU_OP_W  ALU operation
- ex_valid  output  1  EX holds a real instruction
- ex_* (one per id_* above, same width)  output  registered copies
- ex_branch_target  output  DATA_W  id_pc_plus4 + id_imm_shift, registered
- bubble_count  output  CNT_W  number of flush-inserted bubbles

Behaviour:
- All state updates on rising clk. Latency is exactly 1 cycle from id_* to ex_*.
- Priority, evaluated each edge: reset > flush > stall > load.
- reset:
  - every output goes to 0, including ex_valid, ex_branch_target and bubble_count.
  - Reset mid-stream discards the held instruction with no residue.
- flush (stall ignored): bubble.
  - ex_valid=0.
  - ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src = 0.
  - ex_mem_to_reg, ex_reg_dst, ex_alu_op = 0.
  - All data, specifier and target fields = 0.
  - bubble_count increments, saturating at 2^CNT_W-1 with no wrap.
- stall without flush: every ex_* output and bubble_count holds its previous value. Inputs are ignored.
- load (no reset/flush/stall):
  - every ex_* takes its id_* counterpart.
  - ex_valid = id_valid.
  - ex_branch_target = (id_pc_plus4 + id_imm_shift) mod 2^DATA_W. Carry-out is discarded, so wrap-around is legal.
- id_valid=0 on load: the fields are still captured verbatim, but ex_valid=0. This is not counted as a bubble.
- Consecutive stalls hold indefinitely. A flush during a multi-cycle stall ends the hold immediately.
- There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (core_pkg) holds:
  - DATA_W, REG_ADDR_W, ALU_OP_W.
  - The ALU op encodings.
  - The mem_to_reg encodings (00 ALU, 01 memory, 10 PC+4) and reg_dst encodings (00 rt, 01 rd, 10 $31).
  - A packed control-bundle typedef with a BUBBLE constant of all zeros.
- One sub-module, sat_counter: a CNT_W saturating incrementer with synchronous reset, used for bubble_count.
- Everything else is flat register logic.

Test Plan:
1. Reset: assert reset with all id_* nonzero -> next cycle all outputs 0, ex_valid=0, bubble_count=0.
2. Load: id_pc_plus4=0x00400010, id_imm_shift=0x00000020, id_imm_ext=0x00000008, id_valid=1 -> one cycle later ex_branch_target=0x00400030, ex_imm_ext=0x00000008, ex_valid=1.
3. Wrap: id_pc_plus4=0xFFFFFFFC, id_imm_shift=0x00000008 -> ex_branch_target=0x00000004.
4. Stall: stall=1 for 3 cycles while id_* changes every cycle -> ex_* constant. After release, ex_* equals the id_* present on the release edge.
5. Flush over stall: stall=1 and flush=1 with id_reg_write=1, id_mem_write=1 -> ex_reg_write=0, ex_mem_write=0, ex_valid=0, bubble_count +1.
6. Saturation: CNT_W=2, 5 consecutive flushes -> bubble_count sequence 1,2,3,3,3.
